// File: rtl/instruction_fetch_unit.sv
// IF stage and IF/ID register for the 6-stage IITB-RISC pipeline, with squash-flag FSM.
// Optional perf counters enabled by defining FETCH_PERF_COUNTERS_EN.
module instruction_fetch_unit #(
   parameter logic [15:0] RESET_PC  = 16'h0000,
   parameter logic [15:0] NOP_INSTR = 16'h0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        redirect_en,
   input  logic [15:0] redirect_pc,
   input  logic        instr_flush,
   input  logic        instr_flush_2,
   output logic [15:0] imem_addr,
   input  logic [15:0] imem_data,
   output logic [15:0] if_id_instr,
   output logic [15:0] if_id_pc,
   output logic [15:0] if_id_pc_p1,
   output logic        del_instr,
   output logic        del_instr_2,
   output logic [15:0] fetch_count,
   output logic [15:0] squash_count
);

   typedef enum logic {RUN, SQ2} state_e;

   state_e      state_q, state_d;
   logic [15:0] pc_q, pc_d, pc_p1;
   logic [15:0] instr_q, if_pc_q, if_pc_p1_q;
   logic        del_q, del_d, del2_q, del2_d;
   logic        advance, flush_ok;

   always_comb begin
      pc_p1    = pc_q + 16'd1;
      advance  = !stall || redirect_en;
      // A slot that is itself squashed must never request a flush.
      flush_ok = advance && !del_q && !del2_q;

      pc_d = pc_q;
      if (redirect_en)
         pc_d = redirect_pc;
      else if (!stall)
         pc_d = pc_p1;

      state_d = state_q;
      del_d   = del_q;
      del2_d  = del2_q;
      if (advance) begin
         case (state_q)
            RUN: begin
               if (flush_ok && instr_flush_2) begin
                  del_d   = 1'b1;
                  del2_d  = 1'b0;
                  state_d = SQ2;
               end else if (flush_ok && instr_flush) begin
                  del_d  = 1'b1;
                  del2_d = 1'b0;
               end else begin
                  del_d  = 1'b0;
                  del2_d = 1'b0;
               end
            end
            SQ2: begin
               del_d   = 1'b0;
               del2_d  = 1'b1;
               state_d = RUN;
            end
            default: state_d = RUN;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         pc_q       <= RESET_PC;
         instr_q    <= NOP_INSTR;
         if_pc_q    <= 16'h0000;
         if_pc_p1_q <= 16'h0001;
         del_q      <= 1'b1;
         del2_q     <= 1'b0;
         state_q    <= RUN;
      end else begin
         pc_q    <= pc_d;
         state_q <= state_d;
         del_q   <= del_d;
         del2_q  <= del2_d;
         if (advance) begin
            instr_q    <= imem_data;
            if_pc_q    <= pc_q;
            if_pc_p1_q <= pc_p1;
         end
      end
   end

   assign imem_addr   = pc_q;
   assign if_id_instr = instr_q;
   assign if_id_pc    = if_pc_q;
   assign if_id_pc_p1 = if_pc_p1_q;
   assign del_instr   = del_q;
   assign del_instr_2 = del2_q;

`ifdef FETCH_PERF_COUNTERS_EN
   logic [15:0] fetch_cnt_q, squash_cnt_q;

   // Classify the slot being loaded this edge by its next-state flags.
   always_ff @(posedge clk) begin
      if (!reset) begin
         fetch_cnt_q  <= '0;
         squash_cnt_q <= '0;
      end else if (advance) begin
         if (!del_d && !del2_d)
            fetch_cnt_q <= fetch_cnt_q + 16'd1;
         else
            squash_cnt_q <= squash_cnt_q + 16'd1;
      end
   end

   assign fetch_count  = fetch_cnt_q;
   assign squash_count = squash_cnt_q;
`else
   assign fetch_count  = '0;
   assign squash_count = '0;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Randomized bench for instruction_fetch_unit against a pending-squash-count reference model.
module tb_instruction_fetch_unit;

   logic        clk = 1'b0;
   logic        reset, stall, redirect_en, instr_flush, instr_flush_2;
   logic [15:0] redirect_pc, imem_data, imem_addr;
   logic [15:0] if_id_instr, if_id_pc, if_id_pc_p1, fetch_count, squash_count;
   logic        del_instr, del_instr_2;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   // Reference state: squash tracked as "slots still owed" rather than an FSM.
   logic [15:0] m_pc, m_instr, m_ifpc, m_p1, m_fetch, m_squash;
   logic        m_del, m_del2;
   int unsigned m_owed;

   instruction_fetch_unit #(.RESET_PC(16'h0000), .NOP_INSTR(16'h0000)) dut (
      .clk(clk), .reset(reset), .stall(stall), .redirect_en(redirect_en),
      .redirect_pc(redirect_pc), .instr_flush(instr_flush), .instr_flush_2(instr_flush_2),
      .imem_addr(imem_addr), .imem_data(imem_data), .if_id_instr(if_id_instr),
      .if_id_pc(if_id_pc), .if_id_pc_p1(if_id_pc_p1), .del_instr(del_instr),
      .del_instr_2(del_instr_2), .fetch_count(fetch_count), .squash_count(squash_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp)
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      else
         n_pass++;
   endtask

   task automatic model_edge();
      logic n_del, n_del2;
      if (!reset) begin
         m_pc = 16'h0000; m_instr = 16'h0000; m_ifpc = 16'h0000; m_p1 = 16'h0001;
         m_del = 1'b1; m_del2 = 1'b0; m_owed = 0; m_fetch = 16'h0; m_squash = 16'h0;
      end else if (!stall || redirect_en) begin
         n_del = 1'b0; n_del2 = 1'b0;
         if (m_owed > 0) begin
            n_del2 = 1'b1; m_owed = m_owed - 1;
         end else if (!m_del && !m_del2 && instr_flush_2) begin
            n_del = 1'b1; m_owed = 1;
         end else if (!m_del && !m_del2 && instr_flush) begin
            n_del = 1'b1;
         end
         m_del = n_del; m_del2 = n_del2;
         m_instr = imem_data;
         m_ifpc  = m_pc;
         m_p1    = m_pc + 16'd1;
         m_pc    = redirect_en ? redirect_pc : m_pc + 16'd1;
         if (!n_del && !n_del2) m_fetch = m_fetch + 16'd1;
         else m_squash = m_squash + 16'd1;
      end
   endtask

   task automatic compare_all();
      check("imem_addr", imem_addr, m_pc);
      check("if_id_instr", if_id_instr, m_instr);
      check("if_id_pc", if_id_pc, m_ifpc);
      check("if_id_pc_p1", if_id_pc_p1, m_p1);
      check("del_instr", 16'(del_instr), 16'(m_del));
      check("del_instr_2", 16'(del_instr_2), 16'(m_del2));
`ifdef FETCH_PERF_COUNTERS_EN
      check("fetch_count", fetch_count, m_fetch);
      check("squash_count", squash_count, m_squash);
`else
      check("fetch_count", fetch_count, 16'h0000);
      check("squash_count", squash_count, 16'h0000);
`endif
   endtask

   task automatic step(input logic rst_n, input logic stl, input logic re, input logic [15:0] rpc,
                       input logic f1, input logic f2, input logic [15:0] data);
      reset = rst_n; stall = stl; redirect_en = re; redirect_pc = rpc;
      instr_flush = f1; instr_flush_2 = f2; imem_data = data;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare_all();
   endtask

   initial begin
      step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h1111);
      step(1'b0, 1'b1, 1'b1, 16'h55, 1'b1, 1'b1, 16'h2222);
      check("rst_pc", imem_addr, 16'h0000);
      check("rst_pc_p1", if_id_pc_p1, 16'h0001);
      check("rst_del", 16'(del_instr), 16'h0001);

      step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'hA00A);
      step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'hB00B);
      step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'hC00C);
      check("abc_pc", imem_addr, 16'h0003);
      check("abc_instr", if_id_instr, 16'hC00C);
      check("abc_del", 16'(del_instr), 16'h0000);

      // Ten advances after reset with one double flush: 8 clean, 2 squashed.
      step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
      for (int i = 0; i < 10; i++)
         step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, (i == 2), 16'(16'h3000 + i));
`ifdef FETCH_PERF_COUNTERS_EN
      check("perf_fetch", fetch_count, 16'd8);
      check("perf_squash", squash_count, 16'd2);
`endif

      // Stall three cycles with flush held; expect one squashed slot after release.
      step(1'b1, 1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 16'h4444);
      step(1'b1, 1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 16'h4445);
      step(1'b1, 1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 16'h4446);
      step(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h4447);
      check("stall_flush_del", 16'(del_instr), 16'h0001);
      step(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h4448);
      check("stall_flush_once", 16'(del_instr), 16'h0000);

      step(1'b1, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 16'h5555);
      step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h6666);
      check("wrap_pc", imem_addr, 16'h0000);
      check("wrap_pc_p1", if_id_pc_p1, 16'h0000);
      step(1'b1, 1'b1, 1'b1, 16'h0040, 1'b0, 1'b0, 16'h7777);
      check("redir_stall_pc", imem_addr, 16'h0040);

      for (int i = 0; i < 2000; i++) begin
         step(($urandom_range(0, 49) != 0),
              ($urandom_range(0, 9) < 3),
              ($urandom_range(0, 99) < 12),
              ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'hFFFC, 16'hFFFF)) : 16'($urandom),
              ($urandom_range(0, 4) == 0),
              ($urandom_range(0, 6) == 0),
              16'($urandom));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
